// File: rtl/basamak_sayaci_if.sv
// Handshake bundle for basamak_sayaci: digit-code input stream and readout stream.
// slave is the counter block's view, master is the driving side's view.
interface basamak_sayaci_if #(
   parameter int SAYAC_GENISLIGI = 8
);
   logic [1:0]                 basamak;
   logic                       giris_gecerli;
   logic                       giris_hazir;
   logic                       oku;
   logic [SAYAC_GENISLIGI-1:0] cikis_veri;
   logic [1:0]                 cikis_indeks;
   logic                       cikis_gecerli;
   logic                       cikis_hazir;
   logic                       cikis_son;
   logic                       mesgul;

   modport slave (
      input  basamak,
      input  giris_gecerli,
      input  oku,
      input  cikis_hazir,
      output giris_hazir,
      output cikis_veri,
      output cikis_indeks,
      output cikis_gecerli,
      output cikis_son,
      output mesgul
   );

   modport master (
      output basamak,
      output giris_gecerli,
      output oku,
      output cikis_hazir,
      input  giris_hazir,
      input  cikis_veri,
      input  cikis_indeks,
      input  cikis_gecerli,
      input  cikis_son,
      input  mesgul
   );
endinterface

// File: rtl/basamak_sayaci.sv
// Per-digit-code histogram: four counters fed by basamak codes, read out and cleared in order 0..3.
// Optional macro BASAMAK_DOYMA_EN: counters saturate at 2^W-1 instead of wrapping.
module basamak_sayaci #(
   parameter int SAYAC_GENISLIGI = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   basamak_sayaci_if.slave   bus
);
   localparam int W = SAYAC_GENISLIGI;
   localparam logic [W-1:0] TAVAN = {W{1'b1}};

   typedef enum logic {
      SAY = 1'b0,
      OKU = 1'b1
   } durum_t;

   durum_t          durum_q, durum_d;
   logic [1:0]      indeks_q, indeks_d;
   logic [3:0][W-1:0] sayac_tum;
   logic            giris_kabul;
   logic            aktarim;

   assign giris_kabul = (durum_q == SAY) && bus.giris_gecerli;
   assign aktarim     = (durum_q == OKU) && bus.cikis_hazir;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         durum_q  <= SAY;
         indeks_q <= 2'd0;
      end else begin
         durum_q  <= durum_d;
         indeks_q <= indeks_d;
      end
   end

   // An oku arriving with a valid input still counts it: the counters see giris_kabul this same edge.
   always_comb begin
      durum_d  = durum_q;
      indeks_d = indeks_q;
      case (durum_q)
         SAY: begin
            if (bus.oku) begin
               durum_d  = OKU;
               indeks_d = 2'd0;
            end
         end
         OKU: begin
            if (aktarim) begin
               indeks_d = indeks_q + 2'd1;
               if (indeks_q == 2'd3) begin
                  durum_d = SAY;
               end
            end
         end
         default: begin
            durum_d  = SAY;
            indeks_d = 2'd0;
         end
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_sayac
      logic [W-1:0] sayac_q, sayac_d;
      logic [W-1:0] arti_bir;
      logic         secili_giris;
      logic         secili_cikis;

      assign secili_giris = giris_kabul && (bus.basamak == 2'(gi));
      assign secili_cikis = aktarim && (indeks_q == 2'(gi));

`ifdef BASAMAK_DOYMA_EN
      assign arti_bir = (sayac_q == TAVAN) ? TAVAN : sayac_q + 1'b1;
`else
      assign arti_bir = sayac_q + 1'b1;
`endif

      // Counting only happens in SAY and clearing only in OKU, so the two never coincide.
      always_comb begin
         sayac_d = sayac_q;
         if (secili_giris) begin
            sayac_d = arti_bir;
         end else if (secili_cikis) begin
            sayac_d = '0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sayac_q <= '0;
         end else begin
            sayac_q <= sayac_d;
         end
      end

      assign sayac_tum[gi] = sayac_q;
   end

   assign bus.giris_hazir   = (durum_q == SAY);
   assign bus.mesgul        = (durum_q == OKU);
   assign bus.cikis_gecerli = (durum_q == OKU);
   assign bus.cikis_indeks  = indeks_q;
   assign bus.cikis_son     = (durum_q == OKU) && (indeks_q == 2'd3);
   assign bus.cikis_veri    = (durum_q == OKU) ? sayac_tum[indeks_q] : '0;
endmodule

// File: tb/tb_basamak_sayaci.sv
// Directed bench for basamak_sayaci: counting, readout handshake, overflow, stall and reset abort.
module tb_basamak_sayaci;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   basamak_sayaci_if #(.SAYAC_GENISLIGI(W)) bus ();

   basamak_sayaci #(.SAYAC_GENISLIGI(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic [1:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         bus.basamak       = code;
         bus.giris_gecerli = 1'b1;
         tick();
      end
      bus.giris_gecerli = 1'b0;
   endtask

   task automatic start_read();
      bus.oku = 1'b1;
      tick();
      bus.oku = 1'b0;
   endtask

   task automatic readout(input string name, input int e0, input int e1, input int e2, input int e3);
      int exp_w [4];
      exp_w = '{e0, e1, e2, e3};
      bus.cikis_hazir = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_w%0d_gecerli", name, k), 32'(bus.cikis_gecerli), 32'd1);
         check($sformatf("%s_w%0d_indeks", name, k), 32'(bus.cikis_indeks), 32'(k));
         check($sformatf("%s_w%0d_veri", name, k), 32'(bus.cikis_veri), 32'(exp_w[k]));
         check($sformatf("%s_w%0d_son", name, k), 32'(bus.cikis_son), (k == 3) ? 32'd1 : 32'd0);
         check($sformatf("%s_w%0d_hazir", name, k), 32'(bus.giris_hazir), 32'd0);
         $display("%s: word %0d indeks=%0d veri=%0d son=%0b", name, k, bus.cikis_indeks, bus.cikis_veri, bus.cikis_son);
         tick();
      end
      bus.cikis_hazir = 1'b0;
      check({name, "_after_hazir"}, 32'(bus.giris_hazir), 32'd1);
      check({name, "_after_gecerli"}, 32'(bus.cikis_gecerli), 32'd0);
      check({name, "_after_mesgul"}, 32'(bus.mesgul), 32'd0);
   endtask

   initial begin
      int exp_sat;
      checks            = 0;
      errors            = 0;
      rst_n             = 1'b0;
      bus.basamak       = 2'd0;
      bus.giris_gecerli = 1'b0;
      bus.oku           = 1'b0;
      bus.cikis_hazir   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_hazir", 32'(bus.giris_hazir), 32'd1);
      check("rst_gecerli", 32'(bus.cikis_gecerli), 32'd0);
      check("rst_son", 32'(bus.cikis_son), 32'd0);
      check("rst_mesgul", 32'(bus.mesgul), 32'd0);
      check("rst_veri", 32'(bus.cikis_veri), 32'd0);
      $display("reset: hazir=%0b gecerli=%0b mesgul=%0b", bus.giris_hazir, bus.cikis_gecerli, bus.mesgul);

      // Basic histogram 0,1,1,2,3,3,3
      feed(2'd0, 1);
      feed(2'd1, 2);
      feed(2'd2, 1);
      feed(2'd3, 3);
      start_read();
      check("basic_mesgul", 32'(bus.mesgul), 32'd1);
      readout("basic", 1, 2, 1, 3);

      // Back-to-back readout: counters were cleared by the first one
      start_read();
      readout("b2b", 0, 0, 0, 0);

      // Overflow: 300 inputs of code 2
`ifdef BASAMAK_DOYMA_EN
      exp_sat = 255;
`else
      exp_sat = 44;
`endif
      feed(2'd2, 300);
      start_read();
      readout("ovf", 0, 0, exp_sat, 0);

      // oku together with a valid input, then stall; inputs/oku in OKU are ignored
      feed(2'd1, 5);
      bus.basamak       = 2'd1;
      bus.giris_gecerli = 1'b1;
      bus.oku           = 1'b1;
      tick();
      bus.giris_gecerli = 1'b0;
      bus.oku           = 1'b0;
      bus.cikis_hazir   = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("stall%0d_gecerli", c), 32'(bus.cikis_gecerli), 32'd1);
         check($sformatf("stall%0d_indeks", c), 32'(bus.cikis_indeks), 32'd0);
         check($sformatf("stall%0d_veri", c), 32'(bus.cikis_veri), 32'd0);
         check($sformatf("stall%0d_son", c), 32'(bus.cikis_son), 32'd0);
         $display("stall: cycle %0d indeks=%0d veri=%0d", c, bus.cikis_indeks, bus.cikis_veri);
         bus.basamak       = 2'(c);
         bus.giris_gecerli = 1'b1;
         bus.oku           = (c == 1);
         tick();
         bus.giris_gecerli = 1'b0;
         bus.oku           = 1'b0;
      end
      readout("stall", 0, 6, 0, 0);

      // Reset in the middle of a readout
      feed(2'd3, 4);
      start_read();
      bus.cikis_hazir = 1'b1;
      check("abort_w0_veri", 32'(bus.cikis_veri), 32'd0);
      tick();
      check("abort_w1_indeks", 32'(bus.cikis_indeks), 32'd1);
      tick();
      check("abort_w2_indeks", 32'(bus.cikis_indeks), 32'd2);
      rst_n             = 1'b0;
      bus.basamak       = 2'd3;
      bus.giris_gecerli = 1'b1;
      tick();
      rst_n             = 1'b1;
      bus.giris_gecerli = 1'b0;
      bus.cikis_hazir   = 1'b0;
      check("abort_gecerli", 32'(bus.cikis_gecerli), 32'd0);
      check("abort_mesgul", 32'(bus.mesgul), 32'd0);
      check("abort_hazir", 32'(bus.giris_hazir), 32'd1);
      check("abort_veri", 32'(bus.cikis_veri), 32'd0);
      $display("abort: gecerli=%0b hazir=%0b", bus.cikis_gecerli, bus.giris_hazir);
      start_read();
      readout("post_abort", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
